fpmu_byte_loader: RTL and testbench
===================================

FPMU_BYTE_LOADER -- requirements
Module: fpmu_byte_loader

Interface
REQ-001 SHALL have parameter OP_BYTES, default 2, operand/result width in bytes; W = 8*OP_BYTES.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  design enable; low freezes FSM, registers and outputs.
REQ-005 SHALL have port din  input  8  byte bus from input switches.
REQ-006 SHALL have port din_stb  input  1  byte strobe, level from pin; rising edge = one byte event.
REQ-007 SHALL have port op_a  output  W  operand A to multiplier core.
REQ-008 SHALL have port op_b  output  W  operand B to multiplier core.
REQ-009 SHALL have port op_valid  output  1  operands valid.
REQ-010 SHALL have port op_ready  input  1  core accepts operands.
REQ-011 SHALL have port res  input  W  product from core.
REQ-012 SHALL have port res_valid  input  1  product valid.
REQ-013 SHALL have port res_ready  output  1  loader accepts product.
REQ-014 SHALL have port dout  output  8  current result byte for display/uio_out.
REQ-015 SHALL have port dout_valid  output  1  dout holds a result byte.
REQ-016 SHALL have port busy  output  1  high in ISSUE or WAIT_RES.
REQ-017 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-018 SHALL implement FSM states LOAD_A, LOAD_B, ISSUE, WAIT_RES, SEND.
REQ-019 SHALL, per strobe event in LOAD_A, shift din into op_a MSB-first; after OP_BYTES events go to LOAD_B, byte counter cleared.
REQ-020 SHALL load op_b identically in LOAD_B; after OP_BYTES events go to ISSUE.
REQ-021 SHALL assert op_valid only in ISSUE; op_a/op_b stable while op_valid high; op_valid && op_ready in a cycle -> WAIT_RES next cycle.
REQ-022 SHALL assert res_ready only in WAIT_RES; res_valid && res_ready captures res into result register, -> SEND next cycle.
REQ-023 SHALL in SEND drive dout = result byte indexed MSB-first by byte counter, dout_valid = 1; each strobe event advances one byte; event on last byte -> LOAD_A, dout_valid = 0.
REQ-024 SHALL ignore strobe events in ISSUE/WAIT_RES and set ovr; ovr clears only on reset or first byte event in LOAD_A.
REQ-025 SHALL discard strobe events while ena = 0 (edge detector keeps sampling; no retroactive event on ena rise).
REQ-026 SHALL treat held-high strobe as a single event; byte counter wraps to 0 at each state change, never exceeds OP_BYTES-1.
REQ-027 SHALL capture din in the same cycle the event is detected.

Reset
REQ-028 SHALL on rst_n = 0 immediately enter LOAD_A and clear op_a, op_b, result, byte counter, edge/sync flops, ovr; outputs op_valid, res_ready, dout_valid, busy, ovr = 0, dout = 0x00.
REQ-029 SHALL, on reset mid-transaction, abandon it; a pending res_valid after reset is ignored (res_ready = 0).

Configuration
REQ-030 SHALL support macro FPMU_LOADER_SYNC_EN: defined -> din_stb through 2-flop synchronizer then edge register, event detected 3rd rising clk after pin rise; undefined -> din_stb treated synchronous, event 1 cycle after sampled rise (single edge register).

Verification
REQ-031 SHALL pass: bytes 3C,00,40,00 -> op_a=0x3C00, op_b=0x4000, op_valid=1; op_ready=1 one cycle -> busy, res_ready=1.
REQ-032 SHALL pass: in WAIT_RES res=0x4000, res_valid=1 -> dout=0x40 dout_valid=1; one strobe -> dout=0x00; one strobe -> LOAD_A, dout_valid=0.
REQ-033 SHALL pass: op_ready held 0 for 20 cycles -> op_valid, op_a=0x3C00, op_b=0x4000 stable; strobe meanwhile -> ovr=1, operands unchanged.
REQ-034 SHALL pass: rst_n low after 3 operand bytes -> all outputs at reset values within same cycle; next 4 bytes load cleanly.
REQ-035 SHALL pass: strobe held high 50 cycles -> exactly one byte captured; strobe rises with ena=0 -> no capture.
REQ-036 SHALL pass, with and without FPMU_LOADER_SYNC_EN: event latency 3 vs 1 cycles from pin rise to capture.

Source files
------------

// File: rtl/fpmu_byte_loader.sv
// fpmu_byte_loader: byte-serial operand loader / result unloader for a
// multiplier core. Two operands arrive MSB-first over an 8-bit switch bus,
// are handed to the core, and the product is streamed back one byte per
// strobe event.
// Optional build macro FPMU_LOADER_SYNC_EN: routes din_stb through a
// 2-flop synchronizer ahead of the edge register (asynchronous pin).
module fpmu_byte_loader #(
    parameter int unsigned OP_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              din,
    input  logic                    din_stb,
    output logic [8*OP_BYTES-1:0]   op_a,
    output logic [8*OP_BYTES-1:0]   op_b,
    output logic                    op_valid,
    input  logic                    op_ready,
    input  logic [8*OP_BYTES-1:0]   res,
    input  logic                    res_valid,
    output logic                    res_ready,
    output logic [7:0]              dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    ovr
);

    localparam int unsigned W  = 8 * OP_BYTES;
    localparam int unsigned CW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OP_BYTES - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT_RES,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    result_q, result_d;
    logic            ovr_q, ovr_d;
    logic            stb_prev_q, stb_prev_d;
    logic            stb_s;
    logic            evt;
    logic            cnt_last;
    logic [CW-1:0]   cnt_rev;
    logic [W-1:0]    result_shift;

`ifdef FPMU_LOADER_SYNC_EN
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;

    // Synchronizer next-state: the strobe pin is treated as asynchronous.
    always_comb begin
        sync1_d = din_stb;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign stb_s = sync2_q;
`else
    assign stb_s = din_stb;
`endif

    // Rising-edge detect; the edge register samples regardless of ena so
    // an edge seen while disabled is consumed, not replayed later.
    always_comb begin
        stb_prev_d = stb_s;
        evt        = stb_s & ~stb_prev_q & ena;
    end

    // Next-state and datapath updates; everything holds while ena is low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        ovr_d    = ovr_q;
        cnt_last = (cnt_q == CNT_LAST);
        if (ena) begin
            case (state_q)
                LOAD_A: begin
                    if (evt) begin
                        op_a_d = (op_a_q << 8) | W'(din);
                        if (cnt_q == '0) begin
                            ovr_d = 1'b0;
                        end
                        if (cnt_last) begin
                            state_d = LOAD_B;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (evt) begin
                        op_b_d = (op_b_q << 8) | W'(din);
                        if (cnt_last) begin
                            state_d = ISSUE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (evt) begin
                        ovr_d = 1'b1;
                    end
                    if (op_ready) begin
                        state_d = WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (evt) begin
                        ovr_d = 1'b1;
                    end
                    if (res_valid) begin
                        result_d = res;
                        state_d  = SEND;
                        cnt_d    = '0;
                    end
                end
                SEND: begin
                    if (evt) begin
                        if (cnt_last) begin
                            state_d = LOAD_A;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            ovr_q      <= 1'b0;
            stb_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            ovr_q      <= ovr_d;
            stb_prev_q <= stb_prev_d;
        end
    end

    // Outputs decoded from registered state; result bytes selected MSB-first.
    always_comb begin
        cnt_rev      = CNT_LAST - cnt_q;
        result_shift = result_q >> {cnt_rev, 3'b000};
        op_a         = op_a_q;
        op_b         = op_b_q;
        ovr          = ovr_q;
        op_valid     = (state_q == ISSUE);
        res_ready    = (state_q == WAIT_RES);
        busy         = (state_q == ISSUE) || (state_q == WAIT_RES);
        dout_valid   = (state_q == SEND);
        dout         = '0;
        if (state_q == SEND) begin
            dout = result_shift[7:0];
        end
    end

endmodule

// File: tb/tb_fpmu_byte_loader.sv
// Directed self-checking bench for fpmu_byte_loader (OP_BYTES = 2).
module tb_fpmu_byte_loader;

`ifdef FPMU_LOADER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  din;
    logic        din_stb;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] res;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        busy;
    logic        ovr;

    int n_checks = 0;
    int n_fail   = 0;

    fpmu_byte_loader #(.OP_BYTES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (din),
        .din_stb    (din_stb),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clean strobe pulse carrying byte b; returns on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        din     = b;
        din_stb = 1'b1;
        repeat (LAT) @(negedge clk);
        din_stb = 1'b0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_a"},       32'(op_a),       32'h0);
        check({tag, "_op_b"},       32'(op_b),       32'h0);
        check({tag, "_op_valid"},   32'(op_valid),   32'h0);
        check({tag, "_res_ready"},  32'(res_ready),  32'h0);
        check({tag, "_dout"},       32'(dout),       32'h0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
        check({tag, "_busy"},       32'(busy),       32'h0);
        check({tag, "_ovr"},        32'(ovr),        32'h0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        din       = 8'h00;
        din_stb   = 1'b0;
        op_ready  = 1'b0;
        res       = 16'h0;
        res_valid = 1'b0;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First byte doubles as the strobe-to-capture latency measurement.
        din     = 8'h3C;
        din_stb = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) check("lat_early", 32'(op_a), 32'h0000);
            else         check("lat_capture", 32'(op_a), 32'h003C);
        end
        din_stb = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        send_byte(8'h00);
        check("load_a_busy", 32'(busy), 32'h0);
        send_byte(8'h40);
        check("load_b_partial", 32'(op_b), 32'h0040);
        check("load_b_noissue", 32'(op_valid), 32'h0);
        send_byte(8'h00);
        check("issue_op_a", 32'(op_a), 32'h3C00);
        check("issue_op_b", 32'(op_b), 32'h4000);
        check("issue_valid", 32'(op_valid), 32'h1);
        check("issue_busy", 32'(busy), 32'h1);
        check("issue_res_ready", 32'(res_ready), 32'h0);

        // Core stalls: operands must hold, stray strobe sets ovr only.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(op_valid), 32'h1);
            check("stall_op_a", 32'(op_a), 32'h3C00);
            check("stall_op_b", 32'(op_b), 32'h4000);
        end
        check("stall_ovr0", 32'(ovr), 32'h0);
        send_byte(8'h55);
        check("ovr_set", 32'(ovr), 32'h1);
        check("ovr_op_a", 32'(op_a), 32'h3C00);
        check("ovr_op_b", 32'(op_b), 32'h4000);
        check("ovr_still_issue", 32'(op_valid), 32'h1);

        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        check("wait_busy", 32'(busy), 32'h1);
        check("wait_res_ready", 32'(res_ready), 32'h1);
        check("wait_op_valid", 32'(op_valid), 32'h0);
        check("wait_dout_valid", 32'(dout_valid), 32'h0);

        res       = 16'h4000;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res       = 16'hFFFF;
        check("send_b0", 32'(dout), 32'h40);
        check("send_dv0", 32'(dout_valid), 32'h1);
        check("send_busy", 32'(busy), 32'h0);
        check("send_res_ready", 32'(res_ready), 32'h0);
        send_byte(8'hEE);
        check("send_b1", 32'(dout), 32'h00);
        check("send_dv1", 32'(dout_valid), 32'h1);
        send_byte(8'hEE);
        check("send_done_dv", 32'(dout_valid), 32'h0);
        check("send_done_dout", 32'(dout), 32'h00);
        check("ovr_sticky", 32'(ovr), 32'h1);

        // Held strobe with changing din: only the first byte is taken.
        @(negedge clk);
        din     = 8'h12;
        din_stb = 1'b1;
        repeat (25) @(negedge clk);
        din = 8'h99;
        repeat (25) @(negedge clk);
        check("held_op_a", 32'(op_a), 32'h0012);
        check("ovr_cleared", 32'(ovr), 32'h0);
        din_stb = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        // Strobe rising while disabled is lost, even if ena rises mid-pulse.
        ena = 1'b0;
        @(negedge clk);
        din     = 8'h77;
        din_stb = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        ena = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        check("ena_off_op_a", 32'(op_a), 32'h0012);
        din_stb = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        check("ena_off_op_a2", 32'(op_a), 32'h0012);

        // Reset mid-transaction, then a clean reload.
        async_reset("rst1");
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("pre_rst_op_a", 32'(op_a), 32'h1122);
        check("pre_rst_op_b", 32'(op_b), 32'h0033);
        async_reset("rst_mid");
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("reload_op_a", 32'(op_a), 32'hAABB);
        check("reload_op_b", 32'(op_b), 32'hCCDD);
        check("reload_valid", 32'(op_valid), 32'h1);

        // Disabled design ignores the handshake.
        ena      = 1'b0;
        op_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ena_freeze_valid", 32'(op_valid), 32'h1);
        check("ena_freeze_rr", 32'(res_ready), 32'h0);
        ena = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        check("ena_resume_rr", 32'(res_ready), 32'h1);

        // Reset while a product is pending: it must be ignored afterwards.
        res       = 16'h1234;
        res_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("rst_wait_rr", 32'(res_ready), 32'h0);
        check("rst_wait_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_rr", 32'(res_ready), 32'h0);
        check("post_rst_dv", 32'(dout_valid), 32'h0);
        check("post_rst_dout", 32'(dout), 32'h00);
        res_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
